// File: rtl/reg_fifo_readout.sv
// reg_fifo_readout: producer-fed FIFO drained by software through three
// register slots (0 = DATA, 1 = STATUS, 2 = CONTROL).
// Optional feature macro: REG_FIFO_IRQ_EN adds the irq port and the
// CONTROL[23:8] fill-level threshold.
module reg_fifo_readout #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                       S_AXI_ACLK,
   input  logic                       S_AXI_ARESET,
   input  logic                       in_valid,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic                       in_ready,
   input  logic [DATA_WIDTH-1:0]      reg_wrdout,
   input  logic [2:0][3:0]            reg_wrByteStrobe,
   input  logic [2:0]                 reg_rdStrobe,
   output logic [2:0][DATA_WIDTH-1:0] reg_rddin
`ifdef REG_FIFO_IRQ_EN
   ,
   output logic                       irq
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int AW    = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   logic full_s, empty_s, push_s, pop_s, flush_s, clr_s, ovf_ev_s, udf_ev_s, mem_we_s;
   logic [DATA_WIDTH-1:0] status_s;
   logic [DATA_WIDTH-1:0] control_s;

`ifdef REG_FIFO_IRQ_EN
   logic [15:0] thresh_q, thresh_d;
   logic        irq_q, irq_d;
`endif

   // Inputs that no register slot decodes (read strobes of STATUS/CONTROL,
   // byte strobes of DATA/STATUS, unused CONTROL data bits).
   logic unused_s;
   assign unused_s = ^{reg_rdStrobe[2:1], reg_wrByteStrobe[1:0], reg_wrByteStrobe[2][3:1],
                       reg_wrdout};

   // Pointer/count/flag next-state: flush overrides any same-cycle push or pop.
   always_comb begin
      full_s   = (count_q == CNT_W'(FIFO_DEPTH));
      empty_s  = (count_q == {CNT_W{1'b0}});
      push_s   = in_valid & ~full_s;
      pop_s    = reg_rdStrobe[0] & ~empty_s;
      flush_s  = reg_wrByteStrobe[2][0] & reg_wrdout[0];
      clr_s    = reg_wrByteStrobe[2][0] & reg_wrdout[1];
      ovf_ev_s = in_valid & full_s;
      udf_ev_s = reg_rdStrobe[0] & empty_s;
      mem_we_s = push_s & ~flush_s;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_s) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      if (clr_s) begin
         ovf_d = ovf_ev_s;
         udf_d = udf_ev_s;
      end else begin
         ovf_d = ovf_q | ovf_ev_s;
         udf_d = udf_q | udf_ev_s;
      end
   end

`ifdef REG_FIFO_IRQ_EN
   // Threshold byte writes and the irq level computed from the next count.
   always_comb begin
      thresh_d = thresh_q;
      if (reg_wrByteStrobe[2][1]) begin
         thresh_d[7:0] = reg_wrdout[15:8];
      end else begin
         thresh_d[7:0] = thresh_q[7:0];
      end
      if (reg_wrByteStrobe[2][2]) begin
         thresh_d[15:8] = reg_wrdout[23:16];
      end else begin
         thresh_d[15:8] = thresh_q[15:8];
      end
      irq_d = (thresh_q != 16'd0) &&
              ({{(32-CNT_W){1'b0}}, count_d} >= {16'd0, thresh_q});
   end

   // Threshold and irq registers.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         thresh_q <= 16'd0;
         irq_q    <= 1'b0;
      end else begin
         thresh_q <= thresh_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

   // Read-back mux: first-word fall-through DATA, packed STATUS, CONTROL thresh.
   always_comb begin
      status_s  = {DATA_WIDTH{1'b0}};
      control_s = {DATA_WIDTH{1'b0}};
      status_s[CNT_W-1:0] = count_q;
      status_s[16] = empty_s;
      status_s[17] = full_s;
      status_s[18] = ovf_q;
      status_s[19] = udf_q;
`ifdef REG_FIFO_IRQ_EN
      control_s[23:8] = thresh_q;
`endif
      if (empty_s) begin
         reg_rddin[0] = {DATA_WIDTH{1'b0}};
      end else begin
         reg_rddin[0] = mem_q[rd_ptr_q];
      end
      reg_rddin[1] = status_s;
      reg_rddin[2] = control_s;
      in_ready     = ~full_s;
   end

   // Pointer, occupancy and sticky-flag registers.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Word storage; contents are deliberately left unreset.
   always_ff @(posedge S_AXI_ACLK) begin
      if (mem_we_s) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_reg_fifo_readout.sv
// Bench for reg_fifo_readout: directed steps plus random traffic, checked
// against a queue-based model of the register-visible behaviour.
module tb_reg_fifo_readout;

   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic [31:0]      in_data = 32'd0;
   logic             in_ready;
   logic [31:0]      reg_wrdout = 32'd0;
   logic [2:0][3:0]  reg_wrByteStrobe = '0;
   logic [2:0]       reg_rdStrobe = 3'b000;
   logic [2:0][31:0] reg_rddin;
`ifdef REG_FIFO_IRQ_EN
   logic             irq;
`endif

   int checks = 0;
   int failures = 0;

   int unsigned q[$];
   bit          m_ovf = 1'b0;
   bit          m_udf = 1'b0;
   bit [15:0]   m_thr = 16'd0;
   bit          m_irq = 1'b0;

   always #5 clk = ~clk;

   reg_fifo_readout #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
      .S_AXI_ACLK       (clk),
      .S_AXI_ARESET     (rst),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_ready         (in_ready),
      .reg_wrdout       (reg_wrdout),
      .reg_wrByteStrobe (reg_wrByteStrobe),
      .reg_rdStrobe     (reg_rdStrobe),
      .reg_rddin        (reg_rddin)
`ifdef REG_FIFO_IRQ_EN
      ,
      .irq              (irq)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = 32'(q.size());
      s[16] = (q.size() == 0);
      s[17] = (q.size() == DEPTH);
      s[18] = m_ovf;
      s[19] = m_udf;
      return s;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ":status"}, reg_rddin[1], exp_status());
      chk({tag, ":in_ready"}, {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
      chk({tag, ":data"}, reg_rddin[0], (q.size() > 0) ? q[0] : 32'd0);
      chk({tag, ":control"}, reg_rddin[2], {8'd0, m_thr, 8'd0});
`ifdef REG_FIFO_IRQ_EN
      chk({tag, ":irq"}, {31'd0, irq}, {31'd0, m_irq});
`endif
   endtask

   // One bus cycle: drive, check the popped word during the strobe, clock, update model.
   task automatic cyc(input logic v, input logic [31:0] d, input logic rd,
                      input logic [2:0][3:0] strb, input logic [31:0] wd, input string tag);
      int  pre;
      bit  full, empty, flush, clr, oev, uev;
      in_valid = v;
      in_data = d;
      reg_rdStrobe = {2'b00, rd};
      reg_wrByteStrobe = strb;
      reg_wrdout = wd;
      #1;
      if (rd) chk({tag, ":popword"}, reg_rddin[0], (q.size() > 0) ? q[0] : 32'd0);
      @(posedge clk);
      pre = q.size();
      full = (pre == DEPTH);
      empty = (pre == 0);
      flush = strb[2][0] && wd[0];
      clr = strb[2][0] && wd[1];
      oev = v && full;
      uev = rd && empty;
      if (flush) begin
         q.delete();
      end else begin
         if (rd && !empty) void'(q.pop_front());
         if (v && !full) q.push_back(d);
      end
      m_ovf = clr ? oev : (m_ovf | oev);
      m_udf = clr ? uev : (m_udf | uev);
`ifdef REG_FIFO_IRQ_EN
      m_irq = (m_thr != 16'd0) && (q.size() >= int'(m_thr));
      if (strb[2][1]) m_thr[7:0] = wd[15:8];
      if (strb[2][2]) m_thr[15:8] = wd[23:16];
`endif
      #1;
      in_valid = 1'b0;
      reg_rdStrobe = 3'b000;
      reg_wrByteStrobe = '0;
      check_all(tag);
   endtask

   task automatic push(input logic [31:0] d, input string tag);
      cyc(1'b1, d, 1'b0, '0, 32'd0, tag);
   endtask

   task automatic pop(input string tag);
      cyc(1'b0, 32'd0, 1'b1, '0, 32'd0, tag);
   endtask

   task automatic ctrl(input logic [3:0] be, input logic [31:0] wd, input string tag);
      logic [2:0][3:0] s;
      s = '0;
      s[2] = be;
      cyc(1'b0, 32'd0, 1'b0, s, wd, tag);
   endtask

   initial begin
      logic [2:0][3:0] s;
      logic [31:0] word;
      bit v, rd, fl, cl;
      int pv, pr;

      // T1: reset held two cycles
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_thr = 16'd0; m_irq = 1'b0;
      chk("t1:status", reg_rddin[1], 32'h0001_0000);
      chk("t1:in_ready", {31'd0, in_ready}, 32'd1);
      chk("t1:data", reg_rddin[0], 32'd0);
      check_all("t1");

      // T2: fill then drain
      for (int i = 0; i < 16; i++) push(32'h100 + 32'(i), "t2:push");
      chk("t2:full_status", reg_rddin[1], 32'h0002_0010);
      chk("t2:full_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         chk("t2:order", reg_rddin[0], 32'h100 + 32'(i));
         pop("t2:pop");
      end
      chk("t2:empty_status", reg_rddin[1], 32'h0001_0000);

      // T3: overflow, underflow, clear
      for (int i = 0; i < 17; i++) push(32'h200 + 32'(i), "t3:push");
      chk("t3:ovf_status", reg_rddin[1], 32'h0006_0010);
      for (int i = 0; i < 17; i++) pop("t3:pop");
      chk("t3:status", reg_rddin[1], 32'h000D_0000);
      ctrl(4'b0001, 32'h0000_0002, "t3:clr");
      chk("t3:cleared", reg_rddin[1], 32'h0001_0000);

      // T4: simultaneous push+pop, then flush+push
      for (int i = 0; i < 5; i++) push(32'h300 + 32'(i), "t4:push");
      cyc(1'b1, 32'h3AA, 1'b1, '0, 32'd0, "t4:pushpop");
      chk("t4:count", reg_rddin[1] & 32'h1F, 32'd5);
      chk("t4:newhead", reg_rddin[0], 32'h301);
      s = '0; s[2] = 4'b0001;
      cyc(1'b1, 32'h3BB, 1'b0, s, 32'h0000_0001, "t4:flushpush");
      chk("t4:flushed", reg_rddin[1], 32'h0001_0000);

      // Writes to DATA and STATUS must be ignored
      s = '0; s[0] = 4'hF; s[1] = 4'hF;
      cyc(1'b1, 32'h444, 1'b0, s, 32'hFFFF_FFFF, "ign");

      // T5: interleaved traffic across pointer wrap, occupancy 1..3
      push(32'h500, "t5:seed");
      for (int i = 0; i < 40; i++) begin
         word = $urandom;
         if (q.size() <= 1) cyc(1'b1, word, 1'b0, '0, 32'd0, "t5");
         else if (q.size() >= 3) cyc(1'b0, word, 1'b1, '0, 32'd0, "t5");
         else cyc(1'($urandom_range(0, 1)), word, 1'($urandom_range(0, 1)), '0, 32'd0, "t5");
      end

`ifdef REG_FIFO_IRQ_EN
      // T6: threshold interrupt
      ctrl(4'b0001, 32'h0000_0001, "t6:flush");
      ctrl(4'b0010, 32'h0000_0400, "t6:thresh");
      for (int i = 0; i < 4; i++) push(32'h600 + 32'(i), "t6:push");
      chk("t6:irq_on", {31'd0, irq}, 32'd1);
      pop("t6:pop");
      chk("t6:irq_off", {31'd0, irq}, 32'd0);
      ctrl(4'b0110, 32'h0000_0000, "t6:thresh0");
      for (int i = 0; i < 14; i++) push(32'h700 + 32'(i), "t6:fill");
      chk("t6:irq_zero", {31'd0, irq}, 32'd0);
`endif

      // Random traffic: phases biased toward filling and draining
      for (int i = 0; i < 600; i++) begin
         pv = ((i / 100) % 2 == 0) ? 80 : 25;
         pr = 105 - pv;
         v  = ($urandom_range(0, 99) < pv);
         rd = ($urandom_range(0, 99) < pr);
         fl = ($urandom_range(0, 99) < 3);
         cl = ($urandom_range(0, 99) < 8);
         s = '0;
         s[0] = 4'($urandom);
         s[1] = 4'($urandom);
         s[2] = {3'($urandom), fl | cl};
         word = $urandom;
         word[0] = fl;
         word[1] = cl;
         cyc(v, $urandom, rd, s, word, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
